wb_imem_loader: RTL and testbench
=================================

WB_IMEM_LOADER -- requirements
Module: wb_imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the block's 4 KB window.
REQ-002 SHALL have parameter DEPTH, default 64, number of 32-bit instruction words held.
REQ-003 SHALL have one clock and a synchronous, active-high reset: wb_clk_i (in, 1) is the only clock; wb_rst_i (in, 1) is the reset.
REQ-004 wbs_stb_i  in  1  Wishbone strobe.
REQ-005 wbs_cyc_i  in  1  Wishbone cycle.
REQ-006 wbs_we_i  in  1  Wishbone write enable.
REQ-007 wbs_sel_i  in  4  byte-lane selects.
REQ-008 wbs_dat_i  in  32  write data.
REQ-009 wbs_adr_i  in  32  byte address.
REQ-010 wbs_ack_o  out  1  transfer acknowledge.
REQ-011 wbs_dat_o  out  32  read data.
REQ-012 core_rst_o  out  1  reset to the downstream RISC_V core, high = core held in reset.
REQ-013 imem_addr_i  in  log2(DEPTH)  core instruction word address.
REQ-014 imem_data_o  out  32  instruction word at imem_addr_i.

Function
REQ-015 SHALL decode a transfer as selected when wbs_stb_i & wbs_cyc_i and wbs_adr_i[31:12] == BASE_ADDR[31:12].
REQ-016 SHALL map offsets: 0x000 CTRL (R/W, bit0 RUN); 0x004 STATUS (RO, bit0 RUN, bit1 counter saturated); 0x008 CYCLES (RO, 32 bits); 0x100..0x100+4*DEPTH-4 IMEM (R/W, word index wbs_adr_i[2+:log2(DEPTH)]).
REQ-017 SHALL implement a two-state ack FSM: IDLE -> ACK on selected transfer, with the access performed and wbs_ack_o high for that next cycle; ACK -> IDLE unconditionally.
REQ-018 SHALL keep wbs_ack_o low in IDLE and never accept a new transfer while in ACK, so back-to-back accesses complete at most once per 2 cycles.
REQ-019 SHALL acknowledge unmapped offsets inside the window, returning 0 on reads and ignoring writes.
REQ-020 SHALL register wbs_dat_o, valid only while wbs_ack_o=1 and 0 at all other times.
REQ-021 SHALL write IMEM bytes only on lanes with wbs_sel_i[n]=1.
REQ-022 SHALL update CTRL.RUN only when wbs_sel_i[0]=1.
REQ-023 SHALL ignore IMEM writes while RUN=1, still acknowledging them; IMEM reads are allowed at any time.
REQ-024 SHALL drive core_rst_o as a register equal to ~RUN, deasserting the cycle after the ack of the write setting RUN=1.
REQ-025 SHALL provide imem_data_o combinationally from imem_addr_i, so a single-cycle core fetches in the same cycle.
REQ-026 SHALL clear CYCLES on the RUN 0->1 transition, increment it by 1 each cycle while RUN=1, and hold it when RUN=0.
REQ-027 SHALL saturate CYCLES at 32'hFFFF_FFFF, setting STATUS bit1, which clears only with the counter.
REQ-028 SHALL return the pre-update CYCLES value when CYCLES is read in the same cycle it increments.
REQ-029 SHALL have a RUN 1->0 write reassert core_rst_o the following cycle and hold CYCLES.

Reset
REQ-030 SHALL on wb_rst_i=1 at a clock edge set RUN=0, core_rst_o=1, wbs_ack_o=0, wbs_dat_o=0, CYCLES=0, saturation flag=0, and FSM=IDLE.
REQ-031 SHALL leave IMEM contents unchanged on reset.
REQ-032 SHALL have reset asserted mid-transfer abort the transfer with no ack, with the master retrying.

Verification
REQ-033 Write 0x00000013 to 0x3000_0100 with sel=4'hF, then read it back -> ack exactly 1 cycle after each strobe; read data 0x00000013; imem_data_o=0x00000013 when imem_addr_i=0.
REQ-034 Write 0xAABBCCDD to 0x3000_0104 with sel=4'hF, then 0x11223344 with sel=4'b0101 -> word reads 0xAA22CC44.
REQ-035 Write CTRL=1, wait 10 cycles, read CYCLES -> core_rst_o low from the cycle after the ack; CYCLES within 10..12, deterministic per bench timing.
REQ-036 With RUN=1, write 0xFFFFFFFF to 0x3000_0100 -> acked; readback unchanged at 0x00000013.
REQ-037 Strobe held continuously for 6 cycles -> ack pattern 0,1,0,1,0,1; access to 0x3000_1000 -> no ack.
REQ-038 Assert wb_rst_i with RUN=1 and CYCLES nonzero -> next cycle core_rst_o=1, CYCLES=0, STATUS=0; IMEM readback preserved.

Source files
------------

// File: rtl/wb_imem_loader_if.sv
// Wishbone slave bundle for the instruction memory loader.
// The master drives the request and the slave returns ack and data.
interface wb_imem_loader_if;
   logic        stb;
   logic        cyc;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic [31:0] adr;
   logic        ack;
   logic [31:0] dat_r;

   modport master (
      output stb, cyc, we, sel, dat_w, adr,
      input  ack, dat_r
   );

   modport slave (
      input  stb, cyc, we, sel, dat_w, adr,
      output ack, dat_r
   );
endinterface

// File: rtl/wb_imem_loader.sv
// Wishbone-loaded instruction memory with run control and a cycle
// counter; the core is held in reset until software sets RUN.
module wb_imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          DEPTH     = 64,
   localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   wb_imem_loader_if.slave wbs,
   output logic            core_rst_o,
   input  logic [AW-1:0]   imem_addr_i,
   output logic [31:0]     imem_data_o
);

   localparam logic [11:0] OFF_CTRL = 12'h000;
   localparam logic [11:0] OFF_STAT = 12'h004;
   localparam logic [11:0] OFF_CYC  = 12'h008;
   localparam logic [12:0] IMEM_LO  = 13'h100;
   localparam logic [12:0] IMEM_HI  = 13'h100 + 13'(4 * DEPTH);

   typedef enum logic {
      S_IDLE,
      S_ACK
   } state_t;

   state_t      state_q;
   logic        ack_q;
   logic [31:0] dat_q;

   logic        run_q;
   logic        run_d;
   logic        core_rst_q;
   logic [31:0] cycles_q;
   logic [31:0] cycles_d;
   logic        sat_q;
   logic        sat_d;

   logic [31:0] mem_q [DEPTH];

   logic [11:0]   off;
   logic [AW-1:0] widx;
   logic          in_win;
   logic          hit;
   logic          acc;
   logic          is_ctrl;
   logic          is_stat;
   logic          is_cyc;
   logic          is_imem;
   logic          ctrl_wr;
   logic          imem_wr;
   logic [31:0]   rdata;

   // Address decode of the 4 KB window.
   assign off     = wbs.adr[11:0];
   assign widx    = wbs.adr[2 +: AW];
   assign in_win  = (wbs.adr[31:12] == BASE_ADDR[31:12]);
   assign hit     = wbs.stb & wbs.cyc & in_win;
   assign acc     = hit & (state_q == S_IDLE) & ~wb_rst_i;
   assign is_ctrl = (off == OFF_CTRL);
   assign is_stat = (off == OFF_STAT);
   assign is_cyc  = (off == OFF_CYC);
   assign is_imem = ({1'b0, off} >= IMEM_LO)
                 && ({1'b0, off} < IMEM_HI);

   // Writes only land in the idle-to-ack cycle of a transfer.
   assign ctrl_wr = acc & wbs.we & is_ctrl & wbs.sel[0];
   assign imem_wr = acc & wbs.we & is_imem & ~run_q;

   // Read mux; unmapped offsets in the window read as zero.
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         is_ctrl: rdata = {31'b0, run_q};
         is_stat: rdata = {30'b0, sat_q, run_q};
         is_cyc:  rdata = cycles_q;
         is_imem: rdata = mem_q[widx];
         default: rdata = '0;
      endcase
   end

   // Ack FSM: one ack cycle per accepted transfer, then back to idle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (hit) begin
                  state_q <= S_ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= wbs.we ? 32'b0 : rdata;
               end else begin
                  ack_q <= 1'b0;
                  dat_q <= '0;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
               dat_q   <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
               dat_q   <= '0;
            end
         endcase
      end
   end

   // Next state of RUN and the saturating cycle counter.
   always_comb begin
      run_d    = run_q;
      cycles_d = cycles_q;
      sat_d    = sat_q;
      if (ctrl_wr) begin
         run_d = wbs.dat_w[0];
      end
      if (run_d && !run_q) begin
         cycles_d = '0;
         sat_d    = 1'b0;
      end else if (run_q && !sat_q) begin
         cycles_d = cycles_q + 32'd1;
         if (cycles_q == 32'hFFFF_FFFE) begin
            sat_d = 1'b1;
         end
      end
   end

   // Control registers; core reset trails RUN by one cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         run_q      <= 1'b0;
         core_rst_q <= 1'b1;
         cycles_q   <= '0;
         sat_q      <= 1'b0;
      end else begin
         run_q      <= run_d;
         core_rst_q <= ~run_q;
         cycles_q   <= cycles_d;
         sat_q      <= sat_d;
      end
   end

   // Instruction memory keeps its contents across reset.
   always_ff @(posedge wb_clk_i) begin
      if (imem_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs.sel[b]) begin
               mem_q[widx][8*b +: 8] <= wbs.dat_w[8*b +: 8];
            end
         end
      end
   end

   assign wbs.ack     = ack_q;
   assign wbs.dat_r   = dat_q;
   assign core_rst_o  = core_rst_q;
   assign imem_data_o = mem_q[imem_addr_i];

endmodule

// File: tb/tb_wb_imem_loader.sv
// Bench for wb_imem_loader: bus transfers with expected read data
// queued at issue time and compared when the ack arrives.
module tb_wb_imem_loader;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h000;
   localparam logic [31:0] A_STAT = BASE + 32'h004;
   localparam logic [31:0] A_CYC  = BASE + 32'h008;
   localparam logic [31:0] A_IM0  = BASE + 32'h100;
   localparam logic [31:0] A_IM1  = BASE + 32'h104;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  imem_addr = '0;
   logic [31:0] imem_data;
   logic        core_rst;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int run_edge = 0;
   logic [31:0] exp_q[$];

   wb_imem_loader_if bus_if ();

   wb_imem_loader #(
      .BASE_ADDR(BASE),
      .DEPTH(64)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .wbs(bus_if),
      .core_rst_o(core_rst),
      .imem_addr_i(imem_addr),
      .imem_data_o(imem_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic idle_bus();
      bus_if.stb   = 1'b0;
      bus_if.cyc   = 1'b0;
      bus_if.we    = 1'b0;
      bus_if.sel   = 4'h0;
      bus_if.adr   = '0;
      bus_if.dat_w = '0;
   endtask

   // One transfer; lat is edges to ack (0 = none), at is ack edge.
   task automatic bus(input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat,
                      output int at);
      @(posedge clk); #1;
      bus_if.cyc   = 1'b1;
      bus_if.stb   = 1'b1;
      bus_if.we    = we;
      bus_if.sel   = s;
      bus_if.adr   = a;
      bus_if.dat_w = d;
      rd  = '0;
      lat = 0;
      at  = -1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (bus_if.ack === 1'b1) begin
            rd  = bus_if.dat_r;
            lat = i;
            at  = edge_n;
            break;
         end
      end
      idle_bus();
   endtask

   task automatic test_reset();
      idle_bus();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_if.ack !== 1'b0) begin
         errors++;
         $display("FAIL rst_ack got %b want 0", bus_if.ack);
      end
      checks++;
      if (bus_if.dat_r !== 32'h0) begin
         errors++;
         $display("FAIL rst_dat got %h want 0", bus_if.dat_r);
      end
      checks++;
      if (core_rst !== 1'b1) begin
         errors++;
         $display("FAIL rst_core got %b want 1", core_rst);
      end
      rst = 1'b0;
   endtask

   task automatic test_imem_rw();
      logic [31:0] rd;
      logic [31:0] e;
      int lat;
      int at;
      bus(1'b1, A_IM0, 32'h0000_0013, 4'hF, rd, lat, at);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL im_wr_lat got %0d want 1", lat);
      end
      exp_q.push_back(32'h0000_0013);
      bus(1'b0, A_IM0, 32'h0, 4'hF, rd, lat, at);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL im_rd got %h want %h", rd, e);
      end
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL im_rd_lat got %0d want 1", lat);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_if.ack !== 1'b0 || bus_if.dat_r !== 32'h0) begin
         errors++;
         $display("FAIL idle_dat got %b/%h want 0/0",
                  bus_if.ack, bus_if.dat_r);
      end
      imem_addr = 6'd0;
      #1;
      checks++;
      if (imem_data !== 32'h0000_0013) begin
         errors++;
         $display("FAIL fetch0 got %h want 00000013", imem_data);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      logic [31:0] e;
      int lat;
      int at;
      bus(1'b1, A_IM1, 32'hAABB_CCDD, 4'hF, rd, lat, at);
      bus(1'b1, A_IM1, 32'h1122_3344, 4'b0101, rd, lat, at);
      exp_q.push_back(32'hAA22_CC44);
      bus(1'b0, A_IM1, 32'h0, 4'hF, rd, lat, at);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL lanes got %h want %h", rd, e);
      end
      imem_addr = 6'd1;
      #1;
      checks++;
      if (imem_data !== 32'hAA22_CC44) begin
         errors++;
         $display("FAIL fetch1 got %h want aa22cc44", imem_data);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      logic [31:0] e;
      logic [31:0] addrs[4];
      int lat;
      int at;
      bus(1'b1, BASE + 32'h00C, 32'hFFFF_FFFF, 4'hF, rd, lat, at);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL unmap_wr_lat got %0d want 1", lat);
      end
      bus(1'b1, A_STAT, 32'hFFFF_FFFF, 4'hF, rd, lat, at);
      bus(1'b1, A_CYC, 32'hFFFF_FFFF, 4'hF, rd, lat, at);
      addrs[0] = BASE + 32'h00C;
      addrs[1] = BASE + 32'h200;
      addrs[2] = A_STAT;
      addrs[3] = A_CYC;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'h0);
         bus(1'b0, addrs[i], 32'h0, 4'hF, rd, lat, at);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e || lat !== 1) begin
            errors++;
            $display("FAIL unmap_rd%0d got %h/%0d want %h/1",
                     i, rd, lat, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] pat;
      logic [31:0] e;
      logic [31:0] rd;
      int lat;
      int at;
      pat = 6'b101010;
      @(posedge clk); #1;
      bus_if.cyc = 1'b1;
      bus_if.stb = 1'b1;
      bus_if.we  = 1'b0;
      bus_if.sel = 4'hF;
      bus_if.adr = A_IM0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(pat[i] ? 32'h0000_0013 : 32'h0);
         e = exp_q.pop_front();
         checks++;
         if (bus_if.ack !== pat[i] || bus_if.dat_r !== e) begin
            errors++;
            $display("FAIL b2b_%0d got %b/%h want %b/%h",
                     i, bus_if.ack, bus_if.dat_r, pat[i], e);
         end
         @(posedge clk); #1;
      end
      idle_bus();
      bus(1'b0, BASE + 32'h1000, 32'h0, 4'hF, rd, lat, at);
      checks++;
      if (lat !== 0) begin
         errors++;
         $display("FAIL miss_ack got %0d want 0", lat);
      end
   endtask

   task automatic test_run();
      logic [31:0] rd;
      logic [31:0] e;
      int lat;
      int at;
      bus(1'b1, A_CTRL, 32'h1, 4'hF, rd, lat, at);
      run_edge = at;
      checks++;
      if (lat !== 1 || core_rst !== 1'b1) begin
         errors++;
         $display("FAIL run_ack got %0d/%b want 1/1", lat, core_rst);
      end
      @(posedge clk); #1;
      checks++;
      if (core_rst !== 1'b0) begin
         errors++;
         $display("FAIL run_core got %b want 0", core_rst);
      end
      repeat (10) @(posedge clk);
      exp_q.push_back(32'd12);
      bus(1'b0, A_CYC, 32'h0, 4'hF, rd, lat, at);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL cycles got %0d want %0d", rd, e);
      end
      exp_q.push_back(32'h1);
      bus(1'b0, A_STAT, 32'h0, 4'hF, rd, lat, at);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL stat_run got %h want %h", rd, e);
      end
   endtask

   task automatic test_run_lock();
      logic [31:0] rd;
      logic [31:0] e;
      int lat;
      int at;
      bus(1'b1, A_IM0, 32'hFFFF_FFFF, 4'hF, rd, lat, at);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL lock_lat got %0d want 1", lat);
      end
      exp_q.push_back(32'h0000_0013);
      bus(1'b0, A_IM0, 32'h0, 4'hF, rd, lat, at);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL lock_rd got %h want %h", rd, e);
      end
   endtask

   task automatic test_stop();
      logic [31:0] rd;
      logic [31:0] e;
      int lat;
      int at;
      bus(1'b1, A_CTRL, 32'h0, 4'hF, rd, lat, at);
      checks++;
      if (core_rst !== 1'b0) begin
         errors++;
         $display("FAIL stop_ack got %b want 0", core_rst);
      end
      @(posedge clk); #1;
      checks++;
      if (core_rst !== 1'b1) begin
         errors++;
         $display("FAIL stop_core got %b want 1", core_rst);
      end
      repeat (5) @(posedge clk);
      exp_q.push_back(32'(at - run_edge));
      bus(1'b0, A_CYC, 32'h0, 4'hF, rd, lat, at);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL hold got %0d want %0d", rd, e);
      end
      bus(1'b1, A_CTRL, 32'h1, 4'b1110, rd, lat, at);
      exp_q.push_back(32'h0);
      bus(1'b0, A_CTRL, 32'h0, 4'hF, rd, lat, at);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e || core_rst !== 1'b1) begin
         errors++;
         $display("FAIL sel0 got %h/%b want %h/1", rd, core_rst, e);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic [31:0] e;
      logic [31:0] ra[5];
      logic [31:0] rv[5];
      int lat;
      int at;
      bus(1'b1, A_CTRL, 32'h1, 4'h1, rd, lat, at);
      repeat (6) @(posedge clk);
      #1;
      bus_if.cyc = 1'b1;
      bus_if.stb = 1'b1;
      bus_if.we  = 1'b0;
      bus_if.sel = 4'hF;
      bus_if.adr = A_CYC;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus_if.ack !== 1'b0 || core_rst !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst got %b/%b want 0/1",
                  bus_if.ack, core_rst);
      end
      rst = 1'b0;
      idle_bus();
      ra[0] = A_STAT; rv[0] = 32'h0;
      ra[1] = A_CYC;  rv[1] = 32'h0;
      ra[2] = A_CTRL; rv[2] = 32'h0;
      ra[3] = A_IM0;  rv[3] = 32'h0000_0013;
      ra[4] = A_IM1;  rv[4] = 32'hAA22_CC44;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(rv[i]);
         bus(1'b0, ra[i], 32'h0, 4'hF, rd, lat, at);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e || lat !== 1) begin
            errors++;
            $display("FAIL post_rst%0d got %h/%0d want %h/1",
                     i, rd, lat, e);
         end
      end
   endtask

   initial begin
      idle_bus();
      test_reset();
      test_imem_rw();
      test_byte_lanes();
      test_unmapped();
      test_back_to_back();
      test_run();
      test_run_lock();
      test_stop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
